// File: rtl/arbitro_pkg.sv
// ============================================================================
// Module  : arbitro_pkg
// Brief   : Shared types and helpers for the arbitro_nxm word arbiter/router.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package arbitro_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int get_dest(input logic [63:0] word, input int lsb, input int w);
        logic [63:0] t;
        t = (word >> lsb) & ((64'd1 << w) - 64'd1);
        return int'(t[31:0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/arbitro_rr_sel.sv
// ============================================================================
// Module  : arbitro_rr_sel
// Brief   : Rotating-priority picker; first eligible input strictly after ptr,
//           wrapping round so that ptr itself is the last candidate.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module arbitro_rr_sel
    import arbitro_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int PTR_W  = (NUM_IN > 1) ? clog2(NUM_IN) : 1
)(
    input  logic [NUM_IN-1:0] elig,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant,
    output logic              found
);

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_IN; k++) begin
            for (int j = 0; j < NUM_IN; j++) begin
                if (!found && elig[j] && (j == ((int'(ptr) + k) % NUM_IN))) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/arbitro_nxm.sv
// ============================================================================
// Module  : arbitro_nxm
// Brief   : NUM_IN x NUM_OUT FWFT word arbiter/router with per-destination
//           backpressure. Macro ARBITRO_RR_EN selects burst-limited
//           round-robin; otherwise lowest-index fixed priority.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module arbitro_nxm
    import arbitro_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int NUM_OUT  = 4,
    parameter int WIDTH    = 12,
    parameter int DEST_LSB = 10,
    parameter int DEST_W   = 2,
    parameter int BURST    = 2
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN-1:0]       empty,
    input  logic [NUM_IN*WIDTH-1:0] fifo_out,
    input  logic [NUM_OUT-1:0]      almost_full,
    output logic [NUM_IN-1:0]       pop,
    output logic [NUM_OUT-1:0]      push,
    output logic [WIDTH-1:0]        data_out,
    output logic                    idle,
    output logic                    err_dest
);

    localparam int PTR_W = (NUM_IN > 1) ? clog2(NUM_IN) : 1;

    if (BURST < 1 || NUM_IN < 1 || NUM_OUT < 2 || (1 << DEST_W) < NUM_OUT ||
        DEST_LSB + DEST_W > WIDTH) begin : g_bad_params
        $error("arbitro_nxm: invalid parameter set");
    end

    logic [NUM_IN-1:0]  w_elig;
    logic [NUM_IN-1:0]  w_grant;
    logic               w_any_grant;
    logic [WIDTH-1:0]   w_word;
    int                 w_gnt_dest;
    logic               w_bad_dest;
    logic [NUM_OUT-1:0] w_push_next;
    arb_state_t         r_state;

    // Out-of-range destinations stay eligible so they drain instead of wedging the input.
    always_comb begin : p_elig
        int   d;
        logic blocked;
        d       = 0;
        blocked = 1'b0;
        w_elig  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            d       = get_dest(64'(fifo_out[i*WIDTH +: WIDTH]), DEST_LSB, DEST_W);
            blocked = 1'b0;
            for (int o = 0; o < NUM_OUT; o++) begin
                if (d == o && almost_full[o]) blocked = 1'b1;
            end
            w_elig[i] = !empty[i] && (d >= NUM_OUT || !blocked);
        end
    end

`ifdef ARBITRO_RR_EN
    localparam int CNT_W = clog2(BURST + 1);

    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_pick_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_IN-1:0] w_pick;
    logic              w_found;
    logic              w_stay;

    arbitro_rr_sel #(
        .NUM_IN (NUM_IN),
        .PTR_W  (PTR_W)
    ) u_rr_sel (
        .elig  (w_elig),
        .ptr   (r_ptr),
        .grant (w_pick),
        .found (w_found)
    );

    always_comb begin
        w_stay     = 1'b0;
        w_pick_idx = '0;
        w_grant    = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            if (j == int'(r_ptr)) w_stay = w_elig[j] && (int'(r_cnt) < BURST);
            if (w_pick[j]) w_pick_idx = PTR_W'(j);
        end
        for (int j = 0; j < NUM_IN; j++) begin
            w_grant[j] = w_stay ? (j == int'(r_ptr)) : w_pick[j];
        end
    end

    // A cycle without any grant clears the count so the held input restarts a fresh burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_stay) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_found) begin
            r_ptr <= w_pick_idx;
            r_cnt <= CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end
`else
    always_comb begin
        w_grant = '0;
        for (int j = NUM_IN - 1; j >= 0; j--) begin
            if (w_elig[j]) w_grant = NUM_IN'(1) << j;
        end
    end
`endif

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant[i]) w_word = fifo_out[i*WIDTH +: WIDTH];
        end
        w_any_grant = |w_grant;
        w_gnt_dest  = get_dest(64'(w_word), DEST_LSB, DEST_W);
        w_bad_dest  = w_any_grant && (w_gnt_dest >= NUM_OUT);
        w_push_next = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            w_push_next[o] = w_any_grant && (w_gnt_dest == o);
        end
    end

    assign pop = reset ? w_grant : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push     <= '0;
            data_out <= '0;
            idle     <= 1'b1;
            err_dest <= 1'b0;
            r_state  <= ST_IDLE;
        end else begin
            push <= w_push_next;
            idle <= !w_any_grant;
            if (w_any_grant && !w_bad_dest) data_out <= w_word;
            if (w_bad_dest) err_dest <= 1'b1;
            case (r_state)
                ST_IDLE:   if (|w_elig)  r_state <= ST_ACTIVE;
                ST_ACTIVE: if (!(|w_elig)) r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_arbitro_nxm.sv
// ============================================================================
// Module  : tb_arbitro_nxm
// Brief   : Directed self-checking bench for arbitro_nxm (both arbitration builds).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arbitro_nxm;

    localparam int B = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  empty, almost_full, pop, push;
    logic [47:0] fifo_out;
    logic [11:0] data_out;
    logic        idle, err_dest;

    logic [3:0]  empty2, pop2;
    logic [47:0] fifo_out2;
    logic [2:0]  almost_full2, push2;
    logic [11:0] data_out2;
    logic        idle2, err_dest2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arbitro_nxm #(.NUM_IN(4), .NUM_OUT(4), .WIDTH(12), .DEST_LSB(10), .DEST_W(2), .BURST(B)) dut (
        .clk(clk), .reset(reset), .empty(empty), .fifo_out(fifo_out),
        .almost_full(almost_full), .pop(pop), .push(push), .data_out(data_out),
        .idle(idle), .err_dest(err_dest)
    );

    arbitro_nxm #(.NUM_IN(4), .NUM_OUT(3), .WIDTH(12), .DEST_LSB(10), .DEST_W(2), .BURST(B)) dut3 (
        .clk(clk), .reset(reset), .empty(empty2), .fifo_out(fifo_out2),
        .almost_full(almost_full2), .pop(pop2), .push(push2), .data_out(data_out2),
        .idle(idle2), .err_dest(err_dest2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [11:0] w);
        fifo_out[i*12 +: 12] = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  seq3[9];
        int  seq6[4];
        bit  found;
`ifdef ARBITRO_RR_EN
        seq3 = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        seq6 = '{0, 0, 2, 2};
`else
        seq3 = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        seq6 = '{0, 0, 0, 0};
`endif
        reset        = 1'b0;
        empty        = 4'b1110;
        fifo_out     = '0;
        almost_full  = 4'b0000;
        empty2       = 4'b1111;
        fifo_out2    = '0;
        almost_full2 = 3'b000;

        // 1. reset
        #12;
        check("pop_in_reset", 32'(pop), 'h0);
        empty = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rst_push", 32'(push), 'h0);
        check("rst_pop", 32'(pop), 'h0);
        check("rst_idle", 32'(idle), 'h1);
        check("rst_data", 32'(data_out), 'h0);
        check("rst_err", 32'(err_dest), 'h0);

        // 2. single input, dest 2
        set_word(0, 12'b101010100101);
        empty = 4'b1110;
        #1;
        check("single_pop", 32'(pop), 'h1);
        tick();
        check("single_push", 32'(push), 'h4);
        check("single_data", 32'(data_out), 'hAA5);
        check("single_idle", 32'(idle), 'h0);
        empty = 4'b1111;
        tick();
        check("single_push_off", 32'(push), 'h0);
        check("single_idle_back", 32'(idle), 'h1);
        check("single_data_hold", 32'(data_out), 'hAA5);

        // 3. all inputs busy, all dest 0
        for (int i = 0; i < 4; i++) set_word(i, 12'(12'h010 + i));
        empty = 4'b0000;
        for (int c = 0; c < 9; c++) begin
            #1;
            check($sformatf("burst_pop%0d", c), 32'(pop), 32'(1) << seq3[c]);
            tick();
            check($sformatf("burst_push%0d", c), 32'(push), 'h1);
            check($sformatf("burst_data%0d", c), 32'(data_out), 'h10 + seq3[c]);
        end
        empty = 4'b1111;
        tick();

        // 4. backpressure on output 2
        set_word(0, 12'h801);
        set_word(1, 12'h402);
        almost_full = 4'b0100;
        empty = 4'b1100;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("bp_pop%0d", c), 32'(pop), 'h2);
            tick();
            check($sformatf("bp_push%0d", c), 32'(push), 'h2);
        end
        almost_full = 4'b0000;
        found = 1'b0;
        for (int k = 0; k <= B && !found; k++) begin
            #1;
            if (pop[0]) found = 1'b1;
            else tick();
        end
        check("bp_release", 32'(found), 'h1);
        tick();
        check("bp_rel_push", 32'(push), 'h4);
        check("bp_rel_data", 32'(data_out), 'h801);
        empty = 4'b1111;
        tick();

        // 5. bad destination on the 3-output instance
        fifo_out2[11:0] = 12'hC07;
        empty2 = 4'b1110;
        #1;
        check("bad_pop", 32'(pop2), 'h1);
        check("bad_err_pre", 32'(err_dest2), 'h0);
        tick();
        check("bad_push", 32'(push2), 'h0);
        check("bad_err", 32'(err_dest2), 'h1);
        check("bad_idle", 32'(idle2), 'h0);
        check("bad_data_hold", 32'(data_out2), 'h0);
        fifo_out2[11:0] = 12'h433;
        #1;
        check("bad_next_pop", 32'(pop2), 'h1);
        tick();
        check("bad_next_push", 32'(push2), 'h2);
        check("bad_next_data", 32'(data_out2), 'h433);
        check("bad_err_sticky", 32'(err_dest2), 'h1);
        empty2 = 4'b1111;
        tick();
        check("bad_err_sticky2", 32'(err_dest2), 'h1);
        check("main_err_clean", 32'(err_dest), 'h0);

        // 6. inputs 0 and 2, dest 3, then reset mid-stream
        set_word(0, 12'hC11);
        set_word(2, 12'hC22);
        empty = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("pri_pop%0d", c), 32'(pop), 32'(1) << seq6[c]);
            tick();
            check($sformatf("pri_push%0d", c), 32'(push), 'h8);
            check($sformatf("pri_data%0d", c), 32'(data_out), (seq6[c] == 0) ? 'hC11 : 'hC22);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_push", 32'(push), 'h0);
        check("mid_rst_pop", 32'(pop), 'h0);
        check("mid_rst_idle", 32'(idle), 'h1);
        check("mid_rst_data", 32'(data_out), 'h0);
        check("mid_rst_err2", 32'(err_dest2), 'h0);
        @(negedge clk);
        reset = 1'b1;
        empty = 4'b1111;
        tick();
        check("post_rst_push", 32'(push), 'h0);
        check("post_rst_idle", 32'(idle), 'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
